// File: rtl/airi5c_fpu_pkg.sv
// Shared FPU sequencer types and flag constants.
package airi5c_fpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int FLAG_W  = 5;
  localparam int FLAG_NV = 4;
  localparam logic [FLAG_W-1:0] FFLAGS_INVALID = {1'b1, {FLAG_NV{1'b0}}};

endpackage

// File: rtl/airi5c_fpu_result_mux.sv
// Selects one unit's ready, result and flags out of the flattened unit buses.
module airi5c_fpu_result_mux
  import airi5c_fpu_pkg::*;
#(
  parameter int N_UNITS = 4,
  parameter int UNIT_W  = 2
) (
  input  logic [UNIT_W-1:0]         sel,
  input  logic [N_UNITS-1:0]        unit_ready,
  input  logic [32*N_UNITS-1:0]     unit_result,
  input  logic [FLAG_W*N_UNITS-1:0] unit_flags,
  output logic                      ready_sel,
  output logic [31:0]               result_sel,
  output logic [FLAG_W-1:0]         flags_sel
);

  // An out-of-range sel yields all zeros.
  always_comb begin
    ready_sel  = 1'b0;
    result_sel = '0;
    flags_sel  = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (sel == UNIT_W'(i)) begin
        ready_sel  = unit_ready[i];
        result_sel = unit_result[32*i +: 32];
        flags_sel  = unit_flags[FLAG_W*i +: FLAG_W];
      end
    end
  end

endmodule

// File: rtl/airi5c_fpu_sequencer.sv
// Issues one FP operation at a time to a multi-cycle unit and holds its result.
// Optional watchdog on the WAIT state: define FPU_SEQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// ISSUE | load pulse to the selected unit (or skip to DONE for a bad index)
// WAIT  | waiting for the selected unit's ready pulse
// DONE  | result held until resp_ready
module airi5c_fpu_sequencer
  import airi5c_fpu_pkg::*;
#(
  parameter int N_UNITS        = 4,
  parameter int UNIT_W         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic                      kill,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [UNIT_W-1:0]         req_unit,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [31:0]               resp_result,
  output logic [FLAG_W-1:0]         resp_flags,
  output logic                      busy,
  output logic                      timeout,
  output logic [N_UNITS-1:0]        unit_load,
  output logic [N_UNITS-1:0]        unit_kill,
  input  logic [N_UNITS-1:0]        unit_ready,
  input  logic [32*N_UNITS-1:0]     unit_result,
  input  logic [FLAG_W*N_UNITS-1:0] unit_flags
);

  localparam logic [UNIT_W:0] N_UNITS_L = (UNIT_W+1)'(N_UNITS);

  seq_state_t          state_q, state_d;
  logic [UNIT_W-1:0]   sel_q, sel_d;
  logic [31:0]         result_q, result_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic                sel_ok, ready_sel, expire;
  logic [31:0]         result_sel;
  logic [FLAG_W-1:0]   flags_sel;
  logic [N_UNITS-1:0]  sel_oh;

  airi5c_fpu_result_mux #(
    .N_UNITS (N_UNITS),
    .UNIT_W  (UNIT_W)
  ) u_result_mux (
    .sel         (sel_q),
    .unit_ready  (unit_ready),
    .unit_result (unit_result),
    .unit_flags  (unit_flags),
    .ready_sel   (ready_sel),
    .result_sel  (result_sel),
    .flags_sel   (flags_sel)
  );

  assign sel_ok = ({1'b0, sel_q} < N_UNITS_L);

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N_UNITS; i++) sel_oh[i] = (sel_q == UNIT_W'(i));
  end

`ifdef FPU_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A ready or kill in the expiry cycle takes priority over the watchdog.
  assign expire = (state_q == WAIT) && (cnt_q == CNT_LAST) && !ready_sel && !kill;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ISSUE)     cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  // Watchdog absent; TIMEOUT_CYCLES has no effect in this build.
  assign expire = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !kill) begin
          sel_d   = req_unit;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (kill) begin
          state_d = IDLE;
        end else if (!sel_ok) begin
          result_d = '0;
          flags_d  = FFLAGS_INVALID;
          state_d  = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (kill) begin
          state_d = IDLE;
        end else if (ready_sel) begin
          result_d = result_sel;
          flags_d  = flags_sel;
          state_d  = DONE;
        end else if (expire) begin
          result_d = '0;
          flags_d  = FFLAGS_INVALID;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (kill || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign timeout     = expire;
  assign unit_load   = (state_q == ISSUE && sel_ok && !kill) ? sel_oh : '0;
  assign unit_kill   = (kill && state_q != IDLE) ? {N_UNITS{1'b1}} :
                       (expire ? sel_oh : '0);

endmodule

// File: tb/tb_airi5c_fpu_sequencer.sv
// Bench for airi5c_fpu_sequencer: directed scenarios plus randomized traffic
// against a timestamp-based reference model.
module tb_airi5c_fpu_sequencer;
  localparam int N  = 4;
  localparam int UW = 3;
  localparam int TO = 8;
`ifdef FPU_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk;
  logic          n_reset, kill, req_valid, req_ready, resp_valid, resp_ready, busy, timeout;
  logic [UW-1:0] req_unit;
  logic [31:0]   resp_result;
  logic [4:0]    resp_flags;
  logic [N-1:0]  unit_load, unit_kill, unit_ready;
  logic [32*N-1:0] unit_result;
  logic [5*N-1:0]  unit_flags;

  logic [31:0] res_arr [N];
  logic [4:0]  flg_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign unit_result[32*g +: 32] = res_arr[g];
    assign unit_flags[5*g +: 5]    = flg_arr[g];
  end

  airi5c_fpu_sequencer #(.N_UNITS(N), .UNIT_W(UW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_reset(n_reset), .kill(kill),
    .req_valid(req_valid), .req_ready(req_ready), .req_unit(req_unit),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_flags(resp_flags),
    .busy(busy), .timeout(timeout),
    .unit_load(unit_load), .unit_kill(unit_kill), .unit_ready(unit_ready),
    .unit_result(unit_result), .unit_flags(unit_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  bit auto_mode = 1'b0;
  int ready_at [N];

  // Reference model: the operation in flight described by timestamps.
  bit          m_init = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_have = 1'b0;
  int          m_t0, m_resp_t;
  logic [2:0]  m_sel = 3'd0;
  logic [31:0] m_res;
  logic [4:0]  m_flg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    bit         vs, rdy_sel, e_exp, e_rv;
    logic [3:0] oh, e_load, e_kill;
    vs      = m_busy && (m_sel < 3'd4);
    oh      = vs ? (4'b0001 << m_sel[1:0]) : 4'b0000;
    rdy_sel = vs ? unit_ready[m_sel[1:0]] : 1'b0;
    e_load  = (vs && cyc == m_t0 + 1 && !kill) ? oh : 4'b0000;
    e_exp   = TO_EN && vs && !m_have && cyc == m_t0 + 1 + TO && !rdy_sel && !kill;
    e_kill  = (m_busy && kill) ? 4'b1111 : (e_exp ? oh : 4'b0000);
    e_rv    = m_busy && m_have && cyc >= m_resp_t;
    if (m_init) begin
      chk("m_req_ready", 64'(req_ready), 64'(!m_busy));
      chk("m_busy", 64'(busy), 64'(m_busy));
      chk("m_resp_valid", 64'(resp_valid), 64'(e_rv));
      chk("m_unit_load", 64'(unit_load), 64'(e_load));
      chk("m_unit_kill", 64'(unit_kill), 64'(e_kill));
      chk("m_timeout", 64'(timeout), 64'(e_exp));
      if (e_rv) begin
        chk("m_result", 64'(resp_result), 64'(m_res));
        chk("m_flags", 64'(resp_flags), 64'(m_flg));
      end
    end
    if (!n_reset) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_have = 1'b0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (req_valid && !kill) begin
          m_busy   = 1'b1;
          m_t0     = cyc;
          m_sel    = req_unit;
          m_have   = (req_unit >= 3'd4);
          m_resp_t = cyc + 2;
          m_res    = 32'h0;
          m_flg    = 5'b10000;
        end
      end else if (kill) begin
        m_busy = 1'b0;
        m_have = 1'b0;
      end else if (e_rv) begin
        if (resp_ready) begin
          m_busy = 1'b0;
          m_have = 1'b0;
        end
      end else if (vs && !m_have && cyc >= m_t0 + 2) begin
        if (rdy_sel) begin
          m_have   = 1'b1;
          m_resp_t = cyc + 1;
          m_res    = res_arr[m_sel[1:0]];
          m_flg    = flg_arr[m_sel[1:0]];
        end else if (e_exp) begin
          m_have   = 1'b1;
          m_resp_t = cyc + 1;
          m_res    = 32'h0;
          m_flg    = 5'b10000;
        end
      end
    end
    // Unit emulation: schedule a ready pulse (or none) after each observed load.
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (unit_load[i]) ready_at[i] = ($urandom_range(0, 9) == 0) ? -1 : cyc + $urandom_range(1, 10);
      end
    end
  end

  task automatic tick(input bit rst_n, input bit rv, input int u, input bit k, input bit rr,
                      input logic [3:0] rdy);
    @(posedge clk);
    #1;
    cyc++;
    n_reset    = rst_n;
    req_valid  = rv;
    req_unit   = 3'(u);
    kill       = k;
    resp_ready = rr;
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        unit_ready[i] = (ready_at[i] == cyc) ||
                        (($urandom_range(0, 15) == 0) && !(m_busy && m_sel == 3'(i)));
        res_arr[i] = $urandom;
        flg_arr[i] = 5'($urandom);
      end
    end else begin
      unit_ready = rdy;
    end
  endtask

  initial begin
    n_reset = 1'b0; kill = 1'b1; req_valid = 1'b1; req_unit = '0; resp_ready = 1'b0;
    unit_ready = '0;
    for (int i = 0; i < N; i++) begin
      res_arr[i] = 32'h0; flg_arr[i] = 5'h0; ready_at[i] = -1;
    end
    // Reset with kill and req_valid asserted
    repeat (3) tick(0, 1, 0, 1, 0, 4'b0000);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_unit_load", 64'(unit_load), 64'd0);
    chk("rst_unit_kill", 64'(unit_kill), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_result", 64'(resp_result), 64'd0);
    chk("rst_flags", 64'(resp_flags), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0000);

    // Classifier, minimum latency
    res_arr[0] = 32'h00000010; flg_arr[0] = 5'b00000;
    tick(1, 1, 0, 0, 0, 4'b0000); #2 chk("s1_accept", 64'(req_ready), 64'd1);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s1_load", 64'(unit_load), 64'h1);
    tick(1, 0, 0, 0, 0, 4'b0001); #2 chk("s1_no_early_resp", 64'(resp_valid), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0000); #2;
    chk("s1_resp_valid", 64'(resp_valid), 64'd1);
    chk("s1_result", 64'(resp_result), 64'h10);
    chk("s1_flags", 64'(resp_flags), 64'd0);
    tick(1, 0, 0, 0, 1, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b0000); #2;
    chk("s1_idle_ready", 64'(req_ready), 64'd1);
    chk("s1_idle_resp", 64'(resp_valid), 64'd0);

    // Kill in WAIT, late ready ignored
    tick(1, 1, 2, 0, 0, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s2_load", 64'(unit_load), 64'h4);
    tick(1, 0, 0, 1, 0, 4'b0000); #2 chk("s2_kill_all", 64'(unit_kill), 64'hF);
    tick(1, 0, 0, 0, 0, 4'b0100); #2;
    chk("s2_idle", 64'(busy), 64'd0);
    chk("s2_req_ready", 64'(req_ready), 64'd1);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s2_no_resp", 64'(resp_valid), 64'd0);

    // Foreign ready ignored, then hold in DONE for 10 cycles
    res_arr[3] = 32'hDEADBEEF; flg_arr[3] = 5'b11111;
    res_arr[1] = 32'h3F800000; flg_arr[1] = 5'b00001;
    tick(1, 1, 1, 0, 0, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b1000); #2 chk("s3_ignore_other", 64'(resp_valid), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0010);
    tick(1, 1, 0, 0, 0, 4'b0000); #2;
    chk("s3_result", 64'(resp_result), 64'h3F800000);
    chk("s3_flags", 64'(resp_flags), 64'h01);
    res_arr[1] = 32'h12345678; flg_arr[1] = 5'b01010;
    for (int i = 0; i < 9; i++) begin
      tick(1, 1, 0, 0, 0, 4'b0000); #2;
      chk("s4_hold_result", 64'(resp_result), 64'h3F800000);
      chk("s4_hold_flags", 64'(resp_flags), 64'h01);
      chk("s4_req_ready", 64'(req_ready), 64'd0);
      chk("s4_no_load", 64'(unit_load), 64'd0);
    end
    tick(1, 1, 0, 0, 1, 4'b0000); #2 chk("s4_no_turnaround", 64'(req_ready), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s4_idle_after", 64'(busy), 64'd0);

    // Out-of-range unit index
    tick(1, 1, 5, 0, 0, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b0000); #2;
    chk("s5_no_load", 64'(unit_load), 64'd0);
    chk("s5_no_resp_yet", 64'(resp_valid), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0000); #2;
    chk("s5_resp_valid", 64'(resp_valid), 64'd1);
    chk("s5_result", 64'(resp_result), 64'd0);
    chk("s5_flags", 64'(resp_flags), 64'h10);
    tick(1, 0, 0, 0, 1, 4'b0000);

    // Kill in ISSUE suppresses load
    tick(1, 1, 3, 0, 0, 4'b0000);
    tick(1, 0, 0, 1, 0, 4'b0000); #2;
    chk("s6_no_load", 64'(unit_load), 64'd0);
    chk("s6_kill_all", 64'(unit_kill), 64'hF);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s6_idle", 64'(busy), 64'd0);

    // Kill in IDLE blocks acceptance
    tick(1, 1, 0, 1, 0, 4'b0000); #2 chk("s7_no_kill_idle", 64'(unit_kill), 64'd0);
    tick(1, 0, 0, 0, 0, 4'b0000); #2 chk("s7_not_accepted", 64'(busy), 64'd0);

`ifdef FPU_SEQ_TIMEOUT_EN
    // Unit never ready: watchdog fires on the 8th WAIT cycle
    tick(1, 1, 0, 0, 0, 4'b0000);
    tick(1, 0, 0, 0, 0, 4'b0000);
    for (int i = 1; i <= TO; i++) begin
      tick(1, 0, 0, 0, 0, 4'b0000); #2;
      chk("to_pulse", 64'(timeout), (i == TO) ? 64'd1 : 64'd0);
      chk("to_unit_kill", 64'(unit_kill), (i == TO) ? 64'h1 : 64'd0);
    end
    tick(1, 0, 0, 0, 0, 4'b0000); #2;
    chk("to_resp_valid", 64'(resp_valid), 64'd1);
    chk("to_flags", 64'(resp_flags), 64'h10);
    chk("to_result", 64'(resp_result), 64'd0);
    tick(1, 0, 0, 0, 1, 4'b0000);
`endif

    // Randomized traffic
    auto_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      int u;
      u = ($urandom_range(0, 7) == 0) ? 4 + $urandom_range(0, 3) : $urandom_range(0, 3);
      tick($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1, u,
           $urandom_range(0, 24) == 0, $urandom_range(0, 1) == 1, 4'b0000);
    end
    tick(1, 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
